// File: rtl/player_missile_if.sv
// ---------------------------------------------------------------------------
// player_missile_if
// Groups the frame/control inputs, the player and scan positions, and the
// missile outputs of player_missile into one bundle.
//   master : drives startOfFrame, fire, collision, player position, scan pixel;
//            receives missileDR, missileRGB, missileActive, shotFired
//   slave  : the missile block itself (mirror of master)
// ---------------------------------------------------------------------------
interface player_missile_if;
   logic               startOfFrame;
   logic               fire;
   logic               collision;
   logic signed [10:0] playerTopLeftX;
   logic signed [10:0] playerTopLeftY;
   logic [10:0]        pixelX;
   logic [10:0]        pixelY;
   logic               missileDR;
   logic [7:0]         missileRGB;
   logic               missileActive;
   logic               shotFired;

   modport master (
      output startOfFrame, fire, collision,
      output playerTopLeftX, playerTopLeftY, pixelX, pixelY,
      input  missileDR, missileRGB, missileActive, shotFired
   );

   modport slave (
      input  startOfFrame, fire, collision,
      input  playerTopLeftX, playerTopLeftY, pixelX, pixelY,
      output missileDR, missileRGB, missileActive, shotFired
   );
endinterface

// File: rtl/player_missile.sv
// ---------------------------------------------------------------------------
// player_missile
// Single player missile: launched from the centre-top of the player sprite,
// climbs SPEED pixels per frame, and after it ends (top reached or collision)
// waits COOLDOWN_FRAMES frames before it can be fired again.
//
// Ports
//   clk    : system clock
//   reset  : synchronous active-high reset
//   bus    : player_missile_if.slave
//            in : startOfFrame, fire (level), collision (pulse),
//                 playerTopLeftX/Y (signed 11), pixelX/Y (11)
//            out: missileDR (registered, 1-cycle latency), missileRGB,
//                 missileActive (state == FLYING), shotFired (launch pulse)
//
// Build option
//   MISSILE_AUTOFIRE_EN : when defined, holding fire in IDLE arms the
//                         missile (auto relaunch); otherwise only a new
//                         rising edge of fire arms it.
// ---------------------------------------------------------------------------
module player_missile #(
   parameter int          MISSILE_W       = 4,
   parameter int          MISSILE_H       = 8,
   parameter int          PLAYER_W        = 32,
   parameter int          SPEED           = 4,
   parameter int          COOLDOWN_FRAMES = 8,
   parameter int          TOP_LIMIT       = 0,
   parameter logic [7:0]  MISSILE_RGB     = 8'hFC
) (
   input  logic               clk,
   input  logic               reset,
   player_missile_if.slave    bus
);

   localparam int CNT_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

   localparam logic signed [10:0] X_OFS  = 11'(PLAYER_W / 2 - MISSILE_W / 2);
   localparam logic signed [10:0] H_11   = 11'(MISSILE_H);
   localparam logic signed [11:0] W_12   = 12'(MISSILE_W);
   localparam logic signed [11:0] H_12   = 12'(MISSILE_H);
   localparam logic signed [11:0] SPD_12 = 12'(SPEED);
   localparam logic signed [11:0] TOP_12 = 12'(TOP_LIMIT);
   localparam logic [CNT_W-1:0]   CD_LD  = CNT_W'(COOLDOWN_FRAMES);
   localparam logic [CNT_W-1:0]   CNT_1  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } state_t;

   state_t             state_q;
   logic               fire_q;
   logic               fire_pending_q;
   logic [CNT_W-1:0]   cnt_q;
   logic signed [10:0] x_q;
   logic signed [10:0] y_q;
   logic               dr_q;
   logic [7:0]         rgb_q;
   logic               shot_q;

   logic               arm_s;
   logic signed [11:0] y_step_s;
   logic signed [11:0] px_s;
   logic signed [11:0] py_s;
   logic signed [11:0] x_s;
   logic signed [11:0] y_s;
   logic               in_box_s;
   logic               draw_s;

`ifdef MISSILE_AUTOFIRE_EN
   // Held fire keeps re-arming while idle, giving automatic relaunch.
   assign arm_s = bus.fire;
`else
   // Only a fresh press arms; a key held since an earlier shot does not.
   assign arm_s = bus.fire & ~fire_q;
`endif

   // Next Y computed one bit wider so a step past the top cannot wrap.
   assign y_step_s = {y_q[10], y_q} - SPD_12;

   // Pixel coordinates are unsigned; widen with a zero MSB so the box test
   // is a true signed compare against the (possibly negative) missile corner.
   assign px_s     = {1'b0, bus.pixelX};
   assign py_s     = {1'b0, bus.pixelY};
   assign x_s      = {x_q[10], x_q};
   assign y_s      = {y_q[10], y_q};
   assign in_box_s = (px_s >= x_s) && (px_s < x_s + W_12) &&
                     (py_s >= y_s) && (py_s < y_s + H_12);
   assign draw_s   = (state_q == FLYING) && in_box_s;

   assign bus.missileActive = (state_q == FLYING);
   assign bus.missileDR     = dr_q;
   assign bus.missileRGB    = rgb_q;
   assign bus.shotFired     = shot_q;

   // Missile FSM with position, cooldown counter and registered drawing outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         fire_q         <= 1'b0;
         fire_pending_q <= 1'b0;
         cnt_q          <= {CNT_W{1'b0}};
         x_q            <= 11'sd0;
         y_q            <= 11'sd0;
         dr_q           <= 1'b0;
         rgb_q          <= 8'hFF;
         shot_q         <= 1'b0;
      end else begin
         fire_q <= bus.fire;
         shot_q <= 1'b0;
         dr_q   <= draw_s;
         rgb_q  <= draw_s ? MISSILE_RGB : 8'hFF;

         case (state_q)
            IDLE: begin
               if (fire_pending_q && bus.startOfFrame) begin
                  x_q            <= bus.playerTopLeftX + X_OFS;
                  y_q            <= bus.playerTopLeftY - H_11;
                  fire_pending_q <= 1'b0;
                  shot_q         <= 1'b1;
                  state_q        <= FLYING;
               end else if (arm_s) begin
                  fire_pending_q <= 1'b1;
               end else begin
                  fire_pending_q <= fire_pending_q;
               end
            end
            FLYING: begin
               // A hit takes priority over the frame step, freezing Y.
               if (bus.collision) begin
                  cnt_q   <= CD_LD;
                  state_q <= COOLDOWN;
               end else if (bus.startOfFrame) begin
                  if (y_step_s < TOP_12) begin
                     cnt_q   <= CD_LD;
                     state_q <= COOLDOWN;
                  end else begin
                     y_q <= y_step_s[10:0];
                  end
               end else begin
                  y_q <= y_q;
               end
            end
            COOLDOWN: begin
               if (cnt_q == {CNT_W{1'b0}}) begin
                  state_q <= IDLE;
               end else if (bus.startOfFrame) begin
                  cnt_q <= cnt_q - CNT_1;
               end else begin
                  cnt_q <= cnt_q;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/player_missile.md
PLAYER_MISSILE -- requirements
Module: player_missile

Interface
REQ-001 Parameter MISSILE_W, default 4, missile width in pixels.
REQ-002 Parameter MISSILE_H, default 8, missile height in pixels.
REQ-003 Parameter PLAYER_W, default 32, player sprite width used for centring.
REQ-004 Parameter SPEED, default 4, upward pixels per frame.
REQ-005 Parameter COOLDOWN_FRAMES, default 8, frames between missile end and re-arm.
REQ-006 Parameter TOP_LIMIT, default 0, lowest legal missile topLeftY.
REQ-007 Parameter MISSILE_RGB, default 8'hFC, missile colour.
REQ-008 One clock, clk; reset is synchronous and active-high.
REQ-009 clk  input  1  system clock.
REQ-010 reset  input  1  synchronous active-high reset.
REQ-011 startOfFrame  input  1  one-cycle pulse per video frame.
REQ-012 fire  input  1  level, fire key held (from key decoder).
REQ-013 collision  input  1  one-cycle pulse, missile hit something.
REQ-014 playerTopLeftX, playerTopLeftY  input  signed 11 each  current player position.
REQ-015 pixelX, pixelY  input  11 each  current scan pixel.
REQ-016 missileDR  output  1  missile drawing request.
REQ-017 missileRGB  output  8  missile colour.
REQ-018 missileActive  output  1  high while missile in flight.
REQ-019 shotFired  output  1  one-cycle pulse on launch.

Function
REQ-020 FSM states IDLE, FLYING, COOLDOWN shall be implemented.
REQ-021 A rising edge of fire (registered fire 0->1) in IDLE shall set fire_pending; edges in FLYING or COOLDOWN shall be ignored, not queued.
REQ-022 IDLE with fire_pending on startOfFrame shall launch: X = playerTopLeftX + PLAYER_W/2 - MISSILE_W/2, Y = playerTopLeftY - MISSILE_H, clear fire_pending, pulse shotFired that cycle, enter FLYING.
REQ-023 FLYING on startOfFrame: if Y - SPEED < TOP_LIMIT (signed 11-bit compare) enter COOLDOWN, else Y <= Y - SPEED; X unchanged; no wrap-around.
REQ-024 FLYING with collision shall enter COOLDOWN next cycle; collision outside FLYING shall be ignored.
REQ-025 Collision and startOfFrame in the same cycle: collision wins, Y not updated.
REQ-026 COOLDOWN shall load COOLDOWN_FRAMES, decrement on each startOfFrame, enter IDLE when counter reaches 0; COOLDOWN_FRAMES=0 returns to IDLE on the next cycle.
REQ-027 missileActive shall equal (state == FLYING), combinational from state.
REQ-028 missileDR shall be registered, 1-cycle latency: high iff FLYING and X <= pixelX < X+MISSILE_W and Y <= pixelY < Y+MISSILE_H (signed compare).
REQ-029 missileRGB shall be MISSILE_RGB when missileDR is high, else 8'hFF (transparent).

Reset
REQ-030 reset shall force IDLE, fire_pending=0, cooldown counter=0, X=Y=0, fire register=0, missileDR=0, missileActive=0, shotFired=0, missileRGB=8'hFF.
REQ-031 Reset asserted mid-flight or mid-cooldown shall abort to IDLE on the next edge with no shotFired pulse.

Configuration
REQ-032 Macro MISSILE_AUTOFIRE_EN: when defined, fire held high in IDLE shall set fire_pending (level-sensitive), giving automatic relaunch after cooldown; when undefined, only a new fire rising edge arms (REQ-021).

Verification
REQ-033 Player at (100,400), fire 0->1, then startOfFrame -> shotFired pulse, missile at (114,392), missileActive=1.
REQ-034 Missile at Y=392, 3 startOfFrame pulses -> Y=380; pixel (115,385) gives missileDR=1 one cycle later; pixel (118,385) gives 0.
REQ-035 Missile at Y=3, startOfFrame -> COOLDOWN, missileActive=0; after 8 further startOfFrame pulses -> IDLE.
REQ-036 collision and startOfFrame same cycle at Y=200 -> COOLDOWN, Y stays 200, missileDR stops.
REQ-037 fire held high through flight and cooldown -> no relaunch without macro; relaunch on first startOfFrame in IDLE with MISSILE_AUTOFIRE_EN.
REQ-038 reset pulse during FLYING -> IDLE, all outputs at reset values next cycle.
